// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: FSM state codes, funct3 encodings
// and a two's-complement helper. Used by muldiv_seq (optional MULDIV_EARLY_OUT_EN build).
package muldiv_pkg;

    localparam int MAX_XLEN = 64;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t PREP = 3'd1;
    localparam state_t CALC = 3'd2;
    localparam state_t FIX  = 3'd3;
    localparam state_t DONE = 3'd4;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Works at the widest supported width; callers size-cast the result down to XLEN.
    function automatic logic [MAX_XLEN-1:0] twos_neg(input logic [MAX_XLEN-1:0] x);
        return ~x + {{(MAX_XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration over {acc, opr}: shift-add for multiply (right shift),
// restoring trial-subtract for divide (left shift, quotient bit enters at the bottom).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            i_isDiv,
    input  logic [XLEN-1:0] i_acc,
    input  logic [XLEN-1:0] i_opr,
    input  logic [XLEN-1:0] i_operand,
    output logic [XLEN-1:0] o_acc,
    output logic [XLEN-1:0] o_opr
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_shRem;
    logic          w_fits;

    // The shifted partial remainder needs one extra bit before the trial subtract.
    always_comb begin
        w_sum   = {1'b0, i_acc} + (i_opr[0] ? {1'b0, i_operand} : {(XLEN+1){1'b0}});
        w_shRem = {i_acc, i_opr[XLEN-1]};
        w_fits  = (w_shRem >= {1'b0, i_operand});
        if (i_isDiv) begin
            o_opr = {i_opr[XLEN-2:0], w_fits};
            o_acc = w_fits ? XLEN'(w_shRem - {1'b0, i_operand}) : w_shRem[XLEN-1:0];
        end else begin
            o_acc = w_sum[XLEN:1];
            o_opr = {w_sum[0], i_opr[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M MUL/DIV/REM sequencer beside the EX-stage ALU; busy stalls EX until done.
// Defining MULDIV_EARLY_OUT_EN lets trivial cases (x/0, overflow, multiply by 0) finish from PREP.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_opr;
    logic [XLEN-1:0] r_operand;
    logic [XLEN-1:0] r_result;
    logic            r_negRes;
    logic            r_negRem;

    logic            w_isDiv;
    logic            w_signA;
    logic            w_signB;
    logic            w_bZero;
    logic [XLEN-1:0] w_negOpr;
    logic [XLEN-1:0] w_negAcc;
    logic [XLEN-1:0] w_negOperand;
    logic [XLEN-1:0] w_absA;
    logic [XLEN-1:0] w_absB;
    logic [XLEN-1:0] w_stepAcc;
    logic [XLEN-1:0] w_stepOpr;
    logic [XLEN-1:0] w_fixRes;

    // In PREP r_opr/r_operand still hold the raw rs1/rs2 captured at start.
    assign w_isDiv      = r_f3[2];
    assign w_signA      = (r_f3 == F3_MULH || r_f3 == F3_MULHSU || r_f3 == F3_DIV || r_f3 == F3_REM)
                          && r_opr[XLEN-1];
    assign w_signB      = (r_f3 == F3_MULH || r_f3 == F3_DIV || r_f3 == F3_REM) && r_operand[XLEN-1];
    assign w_bZero      = (r_operand == '0);
    assign w_negOpr     = XLEN'(twos_neg(MAX_XLEN'(r_opr)));
    assign w_negAcc     = XLEN'(twos_neg(MAX_XLEN'(r_acc)));
    assign w_negOperand = XLEN'(twos_neg(MAX_XLEN'(r_operand)));
    assign w_absA       = w_signA ? w_negOpr : r_opr;
    assign w_absB       = w_signB ? w_negOperand : r_operand;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_isDiv   (w_isDiv),
        .i_acc     (r_acc),
        .i_opr     (r_opr),
        .i_operand (r_operand),
        .o_acc     (w_stepAcc),
        .o_opr     (w_stepOpr)
    );

    // High-half negate of the 2*XLEN product only carries into the top when the low half is zero.
    always_comb begin
        case (r_f3)
            F3_MULH, F3_MULHSU, F3_MULHU:
                w_fixRes = r_negRes ? ((r_opr == '0) ? w_negAcc : ~r_acc) : r_acc;
            F3_REM, F3_REMU:
                w_fixRes = r_negRem ? w_negAcc : r_acc;
            default:
                w_fixRes = r_negRes ? w_negOpr : r_opr;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            w_ovf;
    logic            w_early;
    logic [XLEN-1:0] w_earlyRes;

    assign w_ovf = (r_f3 == F3_DIV || r_f3 == F3_REM) && (r_opr == {1'b1, {(XLEN-1){1'b0}}})
                   && (&r_operand);

    always_comb begin
        w_early    = 1'b0;
        w_earlyRes = '0;
        if (w_isDiv) begin
            if (w_bZero) begin
                w_early    = 1'b1;
                w_earlyRes = r_f3[1] ? r_opr : '1;
            end else if (w_ovf) begin
                w_early    = 1'b1;
                w_earlyRes = r_f3[1] ? '0 : r_opr;
            end
        end else if (r_opr == '0 || w_bZero) begin
            w_early = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_f3      <= '0;
            r_acc     <= '0;
            r_opr     <= '0;
            r_operand <= '0;
            r_result  <= '0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state   <= PREP;
                        r_f3      <= f3;
                        r_opr     <= op_a;
                        r_operand <= op_b;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                PREP: begin
                    r_acc     <= '0;
                    r_opr     <= w_isDiv ? w_absA : w_absB;
                    r_operand <= w_isDiv ? w_absB : w_absA;
                    r_negRes  <= (w_signA ^ w_signB) && !(w_isDiv && w_bZero);
                    r_negRem  <= w_signA;
                    r_count   <= CW'(XLEN - 1);
`ifdef MULDIV_EARLY_OUT_EN
                    if (w_early) begin
                        r_result <= w_earlyRes;
                        r_state  <= DONE;
                    end else begin
                        r_state <= CALC;
                    end
`else
                    r_state   <= CALC;
`endif
                end
                CALC: begin
                    r_acc <= w_stepAcc;
                    r_opr <= w_stepOpr;
                    if (r_count == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                FIX: begin
                    r_result <= w_fixRes;
                    r_state  <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state == PREP) || (r_state == CALC) || (r_state == FIX);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver queues hand-computed results and done cycles,
// a negedge monitor pops and compares each done pulse. Honours MULDIV_EARLY_OUT_EN latencies.
module tb_muldiv_seq;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int LAT_FULL = 35;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SP = 2;
`else
    localparam int LAT_SP = 35;
`endif

    typedef struct {
        string       name;
        logic [31:0] res;
        int          doneEdge;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  f3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    exp_t expQ[$];
    exp_t monE;
    int   edgeCnt = 0;
    int   lastIssue = 0;
    int   checkCnt = 0;
    int   passCnt = 0;
    int   busyCnt;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .f3     (f3),
        .op_a   (opA),
        .op_b   (opB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] req);
        checkCnt++;
        if (got === req) passCnt++;
        else $display("[TB] FAIL %s: got %h, required %h", name, got, req);
    endtask

    // Drives at the current negedge; done is expected when edgeCnt reaches issue + lat.
    task automatic applyStimulus(input string name, input logic [2:0] fn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] req, input int lat,
                                 input bit expectDone);
        exp_t e;
        f3 = fn;
        opA = a;
        opB = b;
        start = 1'b1;
        lastIssue = edgeCnt;
        if (expectDone) begin
            e.name = name;
            e.res = req;
            e.doneEdge = edgeCnt + lat;
            expQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        f3 = 3'($urandom_range(0, 7));
        opA = $urandom;
        opB = $urandom;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((busy || done || expQ.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput({name, "_timeout"}, 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic waitEdge(input int target);
        int n = 0;
        while (edgeCnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic runOne(input string name, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] req, input int lat);
        applyStimulus(name, fn, a, b, req, lat, 1'b1);
        waitIdle(name);
    endtask

    // Every done pulse must match the oldest outstanding expectation in value and timing.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCnt++;
                $display("[TB] FAIL unexpected_done: got done=1 result %h, required no done", result);
            end else begin
                monE = expQ.pop_front();
                checkOutput(monE.name, result, monE.res);
                checkOutput({monE.name, "_cycle"}, 32'(edgeCnt), 32'(monE.doneEdge));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        f3 = '0;
        opA = '0;
        opB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Busy must be high in cycles 1..34 and low in the done cycle 35.
        applyStimulus("mul_7_m3", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT_FULL, 1'b1);
        busyCnt = 0;
        for (int i = 1; i <= 35; i++) begin
            if (busy) busyCnt++;
            if (i == 35) checkOutput("busy_in_done_cycle", {31'b0, busy}, 32'd0);
            else @(negedge clk);
        end
        checkOutput("busy_cycle_count", 32'(busyCnt), 32'd34);
        waitIdle("mul_7_m3");

        runOne("mulh_min_min",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_FULL);
        runOne("mulhu_max_max",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_FULL);
        runOne("mulhsu_m1_2",    OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, LAT_FULL);
        runOne("mulh_m5_3",      OP_MULH,   32'hFFFFFFFB, 32'h00000003, 32'hFFFFFFFF, LAT_FULL);
        runOne("mulh_min_2",     OP_MULH,   32'h80000000, 32'h00000002, 32'hFFFFFFFF, LAT_FULL);
        runOne("mul_zero",       OP_MUL,    32'h00000000, 32'h00000005, 32'h00000000, LAT_SP);
        runOne("div_m7_2",       OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, LAT_FULL);
        runOne("rem_m7_2",       OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, LAT_FULL);
        runOne("divu_100_7",     OP_DIVU,   32'd100,      32'd7,        32'd14,       LAT_FULL);
        runOne("remu_100_7",     OP_REMU,   32'd100,      32'd7,        32'd2,        LAT_FULL);
        runOne("divu_by_zero",   OP_DIVU,   32'h00001234, 32'h00000000, 32'hFFFFFFFF, LAT_SP);
        runOne("rem_by_zero",    OP_REM,    32'h00001234, 32'h00000000, 32'h00001234, LAT_SP);
        runOne("div_neg_by_0",   OP_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, LAT_SP);
        runOne("rem_neg_by_0",   OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, LAT_SP);
        runOne("div_overflow",   OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SP);
        runOne("rem_overflow",   OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_SP);

        // Starts during busy must neither restart nor add a done pulse.
        applyStimulus("ignored_first", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL, 1'b1);
        waitEdge(lastIssue + 5);
        applyStimulus("ignored_c5", OP_MUL, 32'd3, 32'd3, 32'd9, LAT_FULL, 1'b0);
        waitEdge(lastIssue + 15);
        applyStimulus("ignored_c20", OP_REMU, 32'd50, 32'd8, 32'd2, LAT_FULL, 1'b0);
        waitIdle("ignored_first");
        repeat (40) @(negedge clk);

        // Back-to-back: new start presented in the DONE cycle of the previous op.
        applyStimulus("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) checkOutput("b2b_first_timeout", 32'(n), 32'd0);
        applyStimulus("b2b_second", OP_REMU, 32'd100, 32'd7, 32'd2, LAT_FULL, 1'b1);
        waitIdle("b2b_second");

        // Reset in CALC aborts the op: outputs clear and no done follows.
        applyStimulus("aborted", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT_FULL, 1'b0);
        waitEdge(lastIssue + 10);
        checkOutput("abort_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        reset = 1'b0;
        repeat (45) @(negedge clk);

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
